// File: rtl/soc_membus.sv
// soc_membus: CPU bus decoder with wait-stated internal RAM and a strobe/ack external port.
// Optional macro SOC_MEMBUS_TIMEOUT_EN adds an ext ack timeout (data 16'hFFFF, sticky err_o).
module soc_membus #(
  parameter int          RAM_AW      = 8,
  parameter logic [15:0] RAM_BASE    = 16'h8000,
  parameter int          RAM_WAIT    = 1,
  parameter int          EXT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_i,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        need_wait_o,
  output logic [15:0] ext_addr_o,
  output logic        ext_re_o,
  output logic        ext_we_o,
  output logic [15:0] ext_data_o,
  input  logic [15:0] ext_data_i,
  input  logic        ext_ack_i,
  output logic        err_o
);
  typedef enum logic [1:0] {S_IDLE, S_RAM_WAIT, S_EXT_REQ, S_RESP} state_t;

  localparam logic [16:0] RAM_END = {1'b0, RAM_BASE} + (17'd1 << RAM_AW);
  localparam int CNT_MAX = (RAM_WAIT > EXT_TIMEOUT) ? RAM_WAIT : EXT_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_addr;
  logic [15:0]       r_wdata;
  logic [15:0]       r_rdata;
  logic [15:0]       r_ram_rd;
  logic              r_we;
  logic              r_src_ram;
  logic              r_ext_re;
  logic              r_ext_we;
  logic [15:0]       r_mem [2**RAM_AW];

  logic              w_req;
  logic              w_is_ext;
  logic              w_is_ram;
  logic              w_unmapped;
  logic              w_unmapped_rd;
  logic              w_cnt_zero;
  logic              w_ram_done;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [RAM_AW-1:0] w_ram_idx;

  assign w_req         = re_i | we_i;
  assign w_is_ext      = addr_i < RAM_BASE;
  assign w_is_ram      = !w_is_ext && ({1'b0, addr_i} < RAM_END);
  assign w_unmapped    = !w_is_ext && !w_is_ram;
  assign w_unmapped_rd = (r_state == S_IDLE) && re_i && !we_i && w_unmapped;
  assign w_cnt_zero    = (r_cnt == '0);
  // The RAM access completes on the edge leaving the last wait cycle; reset on that edge cancels it.
  assign w_ram_done    = (r_state == S_RAM_WAIT) && w_cnt_zero && !rst;
  assign w_ram_we      = w_ram_done && r_we;
  assign w_ram_re      = w_ram_done && !r_we;
  assign w_ram_idx     = r_addr[RAM_AW-1:0];

  // Block RAM with an enabled output register so a completed read holds its value.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_idx] <= r_wdata;
    if (w_ram_re) r_ram_rd <= r_mem[w_ram_idx];
  end

`ifdef SOC_MEMBUS_TIMEOUT_EN
  logic r_err;
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_ext_re  <= 1'b0;
      r_ext_we  <= 1'b0;
      r_rdata   <= '0;
      r_src_ram <= 1'b0;
`ifdef SOC_MEMBUS_TIMEOUT_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_unmapped) begin
            if (!we_i) begin
              r_rdata   <= '0;
              r_src_ram <= 1'b0;
            end
          end else if (w_req) begin
            r_addr  <= addr_i;
            r_wdata <= data_i;
            r_we    <= we_i;
            if (w_is_ram) begin
              r_cnt   <= CNT_W'(RAM_WAIT);
              r_state <= S_RAM_WAIT;
            end else begin
              r_cnt    <= '0;
              r_ext_re <= !we_i;
              r_ext_we <= we_i;
              r_state  <= S_EXT_REQ;
            end
          end
        end
        S_RAM_WAIT: begin
          if (w_cnt_zero) begin
            if (!r_we) r_src_ram <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_EXT_REQ: begin
          if (ext_ack_i) begin
            r_ext_re <= 1'b0;
            r_ext_we <= 1'b0;
            if (!r_we) begin
              r_rdata   <= ext_data_i;
              r_src_ram <= 1'b0;
            end
            r_cnt   <= '0;
            r_state <= S_RESP;
          end
`ifdef SOC_MEMBUS_TIMEOUT_EN
          else if (r_cnt == CNT_W'(EXT_TIMEOUT - 1)) begin
            r_ext_re  <= 1'b0;
            r_ext_we  <= 1'b0;
            r_rdata   <= 16'hFFFF;
            r_src_ram <= 1'b0;
            r_err     <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign need_wait_o = ((r_state == S_IDLE) && w_req && !w_unmapped) ||
                       (r_state == S_RAM_WAIT) || (r_state == S_EXT_REQ);
  assign data_o      = w_unmapped_rd ? 16'h0000 : (r_src_ram ? r_ram_rd : r_rdata);
  assign ext_addr_o  = r_addr;
  assign ext_data_o  = r_wdata;
  assign ext_re_o    = r_ext_re;
  assign ext_we_o    = r_ext_we;

endmodule

// File: tb/tb_soc_membus.sv
// tb_soc_membus: randomized CPU transactions against a memory-map reference model,
// with a scoreboard monitor checking latency and data_o at each completion.
module tb_soc_membus;
  localparam int          RAM_AW      = 8;
  localparam logic [15:0] RAM_BASE    = 16'h8000;
  localparam int          RAM_WAIT    = 1;
  localparam int          EXT_TIMEOUT = 64;
  localparam int          RAM_WORDS   = 1 << RAM_AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_i;
  logic        re_i;
  logic        we_i;
  logic [15:0] data_i;
  logic [15:0] data_o;
  logic        need_wait_o;
  logic [15:0] ext_addr_o;
  logic        ext_re_o;
  logic        ext_we_o;
  logic [15:0] ext_data_o;
  logic [15:0] ext_data_i;
  logic        ext_ack_i;
  logic        err_o;

  soc_membus #(
    .RAM_AW(RAM_AW), .RAM_BASE(RAM_BASE), .RAM_WAIT(RAM_WAIT), .EXT_TIMEOUT(EXT_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .re_i(re_i), .we_i(we_i), .data_i(data_i),
    .data_o(data_o), .need_wait_o(need_wait_o), .ext_addr_o(ext_addr_o),
    .ext_re_o(ext_re_o), .ext_we_o(ext_we_o), .ext_data_o(ext_data_o),
    .ext_data_i(ext_data_i), .ext_ack_i(ext_ack_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [15:0] data;
    string       name;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [15:0] ram_ref[RAM_WORDS];
  logic [15:0] ext_ref[int];
  logic [15:0] ext_dev[int];
  logic [15:0] last_read;
  bit          busy = 1'b0;
  int          ack_delay = 0;
  int          stall_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Power-on contents of the external device for words never written.
  function automatic logic [15:0] ext_init(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h1357;
  endfunction

  // 0 = external, 1 = internal RAM, 2 = unmapped
  function automatic int region(input logic [15:0] a);
    int off;
    if (int'(a) < int'(RAM_BASE)) return 0;
    off = int'(a) - int'(RAM_BASE);
    return (off < RAM_WORDS) ? 1 : 2;
  endfunction

  // Issue one CPU access, holding it while stalled; expected result goes to the scoreboard.
  task automatic do_txn(input string nm, input logic [15:0] a, input bit re, input bit we,
                        input logic [15:0] d, input int dly, input bit scramble);
    exp_t e;
    int   kind;
    int   n;
    bit   done;
    kind   = region(a);
    e.name = nm;
    e.lat  = (kind == 1) ? 2 + RAM_WAIT : (kind == 0) ? dly + 2 : 0;
    if (we) begin
      if (kind == 1) ram_ref[int'(a) - int'(RAM_BASE)] = d;
      else if (kind == 0) ext_ref[int'(a)] = d;
      e.data = last_read;
    end else begin
      if (kind == 1) e.data = ram_ref[int'(a) - int'(RAM_BASE)];
      else if (kind == 0) e.data = ext_ref.exists(int'(a)) ? ext_ref[int'(a)] : ext_init(a);
      else e.data = 16'h0000;
      last_read = e.data;
    end
    exp_q.push_back(e);
    ack_delay = dly;
    addr_i = a; re_i = re; we_i = we; data_i = d; busy = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (!need_wait_o) done = 1'b1;
      else begin
        n++;
        // Once accepted, the latched request must ignore input changes.
        if (scramble && n >= 2) begin
          addr_i = 16'($urandom);
          data_i = 16'($urandom);
        end
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_complete: still stalled after 200 cycles, expected completion", nm);
      finish_run();
    end
    @(posedge clk);
    #1;
    re_i = 1'b0; we_i = 1'b0; busy = 1'b0;
  endtask

  // Scoreboard monitor: counts stall cycles and checks each completion.
  always @(negedge clk) begin
    if (busy) begin
      if (need_wait_o) stall_cnt++;
      else begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("%s_latency", e.name), stall_cnt, e.lat);
          check($sformatf("%s_data", e.name), data_o, e.data);
        end
        stall_cnt = 0;
      end
    end
  end

  // External device: acks after ack_delay extra cycles, stray acks while idle.
  initial begin : ext_responder
    logic [15:0] a;
    logic [15:0] wd;
    logic        w;
    int          d;
    bit          stable;
    ext_ack_i  = 1'b0;
    ext_data_i = 16'h0000;
    forever begin
      @(negedge clk);
      ext_ack_i = 1'b0;
      if (ext_re_o || ext_we_o) begin
        a = ext_addr_o; w = ext_we_o; wd = ext_data_o; d = ack_delay; stable = 1'b1;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (!(ext_re_o || ext_we_o) || ext_addr_o !== a || ext_data_o !== wd || ext_we_o !== w)
            stable = 1'b0;
        end
        if (w) ext_dev[int'(a)] = wd;
        ext_data_i = w ? 16'h0000 : (ext_dev.exists(int'(a)) ? ext_dev[int'(a)] : ext_init(a));
        ext_ack_i = 1'b1;
        @(negedge clk);
        ext_ack_i  = 1'b0;
        ext_data_i = 16'hDEAD;
        check("ext_strobe_stable", 32'(stable), 1);
        check("ext_strobe_drop", {ext_re_o, ext_we_o}, 0);
      end else if ($urandom_range(0, 7) == 0) begin
        ext_ack_i  = 1'b1;
        ext_data_i = 16'hDEAD;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] prev;
    logic [15:0] a;
    int          sel;
    int          op;
    rst = 1'b1; addr_i = '0; re_i = 1'b0; we_i = 1'b0; data_i = '0; last_read = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_need_wait", need_wait_o, 0);
    check("rst_ext_strobes", {ext_re_o, ext_we_o}, 0);
    check("rst_data_o", data_o, 0);
    check("rst_err_o", err_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < RAM_WORDS; i++)
      do_txn("ram_fill", RAM_BASE + 16'(i), 1'b0, 1'b1, 16'($urandom), 0, 1'b0);

    do_txn("wr_8005", 16'h8005, 1'b0, 1'b1, 16'h1234, 0, 1'b0);
    do_txn("rd_8005", 16'h8005, 1'b1, 1'b0, 16'h0000, 0, 1'b0);
    do_txn("wr_0010", 16'h0010, 1'b0, 1'b1, 16'hBEEF, 2, 1'b0);
    do_txn("rd_0010_ack4", 16'h0010, 1'b1, 1'b0, 16'h0000, 4, 1'b0);
    do_txn("rd_ffff_unmapped", 16'hFFFF, 1'b1, 1'b0, 16'h0000, 0, 1'b0);
    do_txn("rw_both_8001", 16'h8001, 1'b1, 1'b1, 16'h00AA, 0, 1'b0);
    do_txn("rd_8001", 16'h8001, 1'b1, 1'b0, 16'h0000, 0, 1'b0);
    do_txn("rd_7fff_ext_edge", 16'h7FFF, 1'b1, 1'b0, 16'h0000, 0, 1'b0);
    do_txn("rd_80ff_ram_edge", 16'h80FF, 1'b1, 1'b0, 16'h0000, 0, 1'b0);
    do_txn("wr_8100_dropped", 16'h8100, 1'b0, 1'b1, 16'h5555, 0, 1'b0);
    do_txn("rd_8100_unmapped", 16'h8100, 1'b1, 1'b0, 16'h0000, 0, 1'b0);

    // Reset on the RAM commit edge of a write: contents must be untouched.
    prev = ram_ref[2];
    addr_i = 16'h8002; we_i = 1'b1; re_i = 1'b0; data_i = ~prev;
    repeat (1 + RAM_WAIT) @(posedge clk);
    #1 rst = 1'b1; we_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_need_wait", need_wait_o, 0);
    check("midrst_data_o", data_o, 0);
    check("midrst_ext_strobes", {ext_re_o, ext_we_o}, 0);
    last_read = 16'h0000;
    @(posedge clk);
    #1;
    do_txn("rd_8002_after_rst", 16'h8002, 1'b1, 1'b0, 16'h0000, 0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4) a = RAM_BASE + 16'($urandom_range(0, RAM_WORDS - 1));
      else if (sel < 7) a = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom_range(0, 63));
      else a = 16'($urandom_range(int'(RAM_BASE) + RAM_WORDS, 65535));
      op = int'($urandom_range(0, 2));
      do_txn($sformatf("rand%0d", t), a, op != 1, op != 0, 16'($urandom),
             int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("final_err_o", err_o, 0);
    check("queue_empty", exp_q.size(), 0);
    finish_run();
  end

endmodule
